// File: rtl/core_pkg.sv
// core_pkg: forward-select codes, hazard FSM states and shadow-stage tag shared by the ALU, ID/EX and hazard unit
package core_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } shadow_t;
endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-side instruction fields in, forward selects and stall/bubble/flush controls out
// master = ID stage / pipeline control, slave = hazard_forward_unit; wb is the retiring destination tag
interface hazard_forward_unit_if;
  import core_pkg::*;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall_if_id;
  logic       bubble_id_ex;
  logic       flush;
  hz_state_t  state;
  shadow_t    wb;
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read,
    input  forward_a, forward_b, stall_if_id, bubble_id_ex, flush, state, wb
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_reg_write, id_mem_read,
    output forward_a, forward_b, stall_if_id, bubble_id_ex, flush, state, wb
  );
endinterface

// File: rtl/fwd_select.sv
// fwd_select: compares one source register against the EX and MEM shadows, giving the next-cycle select and a load hit
// en/src: source read flag and register; ex: EX shadow; mem_*: MEM shadow; sel: forward code; ld_hit: load-use on this source
module fwd_select
  import core_pkg::*;
(
  input  logic       en,
  input  logic [4:0] src,
  input  shadow_t    ex,
  input  logic       mem_v,
  input  logic [4:0] mem_rd,
  input  logic       mem_wr,
  output logic [1:0] sel,
  output logic       ld_hit
);
  logic ex_hit, mem_hit;
  assign ex_hit  = en & ex.v & ex.wr & (|ex.rd) & (ex.rd == src);
  assign mem_hit = en & mem_v & mem_wr & (|mem_rd) & (mem_rd == src);
  assign sel     = (ex_hit & ~ex.ld) ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_REG;
  assign ld_hit  = ex_hit & ex.ld;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: registered EX forward selects plus combinational load-use stall and branch-flush control
// clk/rst_n: clock, async active-low reset; hold: global freeze; ex_branch_taken: EX redirect;
// bus: ID fields in, selects/controls out; stall_cnt/flush_cnt: saturating event counters
module hazard_forward_unit
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 ex_branch_taken,
  hazard_forward_unit_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);
  shadow_t    ex, mem, wb;
  hz_state_t  state;
  logic [1:0] sel_a, sel_b, fwd_a, fwd_b;
  logic       hit_a, hit_b, load_use, bubble, flush, kill;
  fwd_select u_sel_a (
    .en(bus.id_uses_rs1), .src(bus.id_rs1), .ex(ex),
    .mem_v(mem.v), .mem_rd(mem.rd), .mem_wr(mem.wr),
    .sel(sel_a), .ld_hit(hit_a)
  );
  fwd_select u_sel_b (
    .en(bus.id_uses_rs2), .src(bus.id_rs2), .ex(ex),
    .mem_v(mem.v), .mem_rd(mem.rd), .mem_wr(mem.wr),
    .sel(sel_b), .ld_hit(hit_b)
  );
  assign load_use         = bus.id_valid & (hit_a | hit_b);
  assign bubble           = load_use & ~ex_branch_taken & ~hold;
  assign flush            = ex_branch_taken & ~hold;
  assign kill             = bubble | flush;
  assign bus.stall_if_id  = bubble;
  assign bus.bubble_id_ex = bubble;
  assign bus.flush        = flush;
  assign bus.forward_a    = fwd_a;
  assign bus.forward_b    = fwd_b;
  assign bus.state        = state;
  assign bus.wb           = wb;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex        <= '0;
      mem       <= '0;
      wb        <= '0;
      fwd_a     <= FWD_REG;
      fwd_b     <= FWD_REG;
      stall_cnt <= '0;
      flush_cnt <= '0;
      state     <= RUN;
    end else if (!hold) begin
      wb    <= mem;
      mem   <= ex;
      ex    <= kill ? '0 : '{bus.id_valid, bus.id_rd, bus.id_reg_write, bus.id_mem_read};
      fwd_a <= kill ? FWD_REG : sel_a;
      fwd_b <= kill ? FWD_REG : sel_b;
      if (bubble && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      state <= (state == RUN) ? (flush ? FLUSH : bubble ? STALL : RUN) : RUN;
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: scoreboard bench for forwarding, load-use stall, flush priority, hold and async reset
module tb_hazard_forward_unit;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst_n, hold, br;
  logic [15:0] stall_cnt, flush_cnt;
  hazard_forward_unit_if bus();
  hazard_forward_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .ex_branch_taken(br),
    .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  int chk = 0;
  int err = 0;
  shadow_t m_ex, m_mem;
  hz_state_t m_st;
  logic [15:0] m_sc, m_fc;
  logic e_stall, e_flush;
  logic [3:0] q[$];
  logic [3:0] e;

  function automatic logic mt(shadow_t s, logic [4:0] src, logic en);
    return en && s.v && s.wr && s.rd != 5'd0 && s.rd == src;
  endfunction

  function automatic logic [1:0] msel(logic [4:0] src, logic en);
    if (mt(m_ex, src, en) && !m_ex.ld) return 2'b10;
    if (mt(m_mem, src, en)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_st = RUN; m_sc = '0; m_fc = '0; q.delete();
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, rs2, input logic u1, u2,
                        input logic [4:0] rd, input logic wr, ld, b, h);
    bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2; bus.id_rd = rd;
    bus.id_reg_write = wr; bus.id_mem_read = ld; br = b; hold = h;
    #1;
    e_stall = v && ((mt(m_ex, rs1, u1) || mt(m_ex, rs2, u2)) && m_ex.ld) && !b && !h;
    e_flush = b && !h;
    if (!h) q.push_back((e_stall || e_flush) ? 4'b0000 : {msel(rs1, u1), msel(rs2, u2)});
  endtask

  task automatic tick();
    if (!hold) begin
      m_mem = m_ex;
      m_ex = (e_stall || e_flush) ? '0 : '{bus.id_valid, bus.id_rd, bus.id_reg_write, bus.id_mem_read};
      if (e_stall && m_sc != 16'hffff) m_sc++;
      if (e_flush && m_fc != 16'hffff) m_fc++;
      m_st = (m_st == RUN) ? (e_flush ? FLUSH : e_stall ? STALL : RUN) : RUN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    void'(q.pop_front());
  endtask

  task automatic test_reset();
    br = 1'b1; hold = 1'b0;
    #1;
    chk++;
    if (bus.flush !== 1'b1) begin err++; $display("FAIL rst_flush got %b want 1", bus.flush); end
    br = 1'b0;
    #1;
    chk++;
    if ({bus.stall_if_id, bus.bubble_id_ex, bus.flush, bus.forward_a, bus.forward_b} !== 7'd0) begin
      err++; $display("FAIL rst_out got %b want 0000000",
                      {bus.stall_if_id, bus.bubble_id_ex, bus.flush, bus.forward_a, bus.forward_b});
    end
    chk++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || bus.state !== RUN) begin
      err++; $display("FAIL rst_state got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, bus.state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_ex();
    set_id(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e) begin err++; $display("FAIL fwd_add got %b want %b", {bus.forward_a, bus.forward_b}, e); end
    set_id(1, 5, 3, 1, 1, 8, 1, 0, 0, 0);
    chk++;
    if (bus.stall_if_id !== 1'b0) begin err++; $display("FAIL fwd_ex_stall got %b want 0", bus.stall_if_id); end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e) begin err++; $display("FAIL fwd_ex got %b want %b", {bus.forward_a, bus.forward_b}, e); end
    chk++;
    if ({bus.forward_a, bus.forward_b} !== 4'b1000) begin err++; $display("FAIL fwd_ex_abs got %b want 1000", {bus.forward_a, bus.forward_b}); end
  endtask

  task automatic test_load_use();
    idle(); idle();
    set_id(1, 1, 2, 1, 0, 6, 1, 1, 0, 0);
    tick();
    void'(q.pop_front());
    set_id(1, 1, 6, 1, 1, 10, 1, 0, 0, 0);
    chk++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== {e_stall, e_stall} || e_stall !== 1'b1) begin
      err++; $display("FAIL lu_stall got %b%b want 11", bus.stall_if_id, bus.bubble_id_ex);
    end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e) begin err++; $display("FAIL lu_bubble_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e); end
    chk++;
    if (stall_cnt !== 16'd1 || bus.state !== STALL) begin err++; $display("FAIL lu_cnt got %0d/%0d want 1/%0d", stall_cnt, bus.state, STALL); end
    set_id(1, 1, 6, 1, 1, 10, 1, 0, 0, 0);
    chk++;
    if (bus.stall_if_id !== 1'b0) begin err++; $display("FAIL lu_once got %b want 0", bus.stall_if_id); end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e || bus.forward_b !== 2'b01) begin
      err++; $display("FAIL lu_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e);
    end
    chk++;
    if (bus.state !== m_st || stall_cnt !== m_sc) begin err++; $display("FAIL lu_run got %0d/%0d want %0d/%0d", bus.state, stall_cnt, m_st, m_sc); end
  endtask

  task automatic test_x0();
    idle(); idle();
    set_id(1, 1, 2, 1, 1, 0, 1, 1, 0, 0);
    tick();
    void'(q.pop_front());
    set_id(1, 0, 3, 1, 1, 11, 1, 0, 0, 0);
    chk++;
    if (bus.stall_if_id !== 1'b0) begin err++; $display("FAIL x0_stall got %b want 0", bus.stall_if_id); end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e || bus.forward_a !== 2'b00) begin
      err++; $display("FAIL x0_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e);
    end
  endtask

  task automatic test_priority();
    idle(); idle();
    set_id(1, 1, 2, 1, 1, 7, 1, 0, 0, 0); tick(); void'(q.pop_front());
    set_id(1, 3, 4, 1, 1, 7, 1, 0, 0, 0); tick(); void'(q.pop_front());
    set_id(1, 7, 7, 1, 0, 12, 1, 0, 0, 0);
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e || bus.forward_a !== 2'b10) begin
      err++; $display("FAIL prio_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e);
    end
    idle(); idle();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 0, 0); tick(); void'(q.pop_front());
    idle();
    set_id(1, 3, 9, 1, 1, 13, 1, 0, 0, 0);
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e || bus.forward_b !== 2'b01) begin
      err++; $display("FAIL memwb_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e);
    end
  endtask

  task automatic test_flush_vs_load();
    idle(); idle();
    set_id(1, 1, 2, 1, 1, 6, 1, 1, 0, 0); tick(); void'(q.pop_front());
    set_id(1, 1, 6, 1, 1, 14, 1, 0, 1, 0);
    chk++;
    if ({bus.flush, bus.stall_if_id, bus.bubble_id_ex} !== 3'b100) begin
      err++; $display("FAIL fl_ctrl got %b want 100", {bus.flush, bus.stall_if_id, bus.bubble_id_ex});
    end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e) begin err++; $display("FAIL fl_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e); end
    chk++;
    if (flush_cnt !== 16'd1 || stall_cnt !== m_sc || bus.state !== FLUSH) begin
      err++; $display("FAIL fl_cnt got %0d/%0d/%0d want 1/%0d/%0d", flush_cnt, stall_cnt, bus.state, m_sc, FLUSH);
    end
    idle();
    chk++;
    if (bus.state !== RUN) begin err++; $display("FAIL fl_ret got %0d want %0d", bus.state, RUN); end
  endtask

  task automatic test_hold_reset();
    logic [3:0] last;
    idle(); idle();
    set_id(1, 1, 2, 1, 1, 6, 1, 1, 0, 0); tick(); last = q.pop_front();
    set_id(1, 1, 6, 1, 1, 15, 1, 0, 1, 1);
    chk++;
    if ({bus.stall_if_id, bus.bubble_id_ex, bus.flush} !== 3'b000) begin
      err++; $display("FAIL hold_ctrl got %b want 000", {bus.stall_if_id, bus.bubble_id_ex, bus.flush});
    end
    tick();
    chk++;
    if ({bus.forward_a, bus.forward_b} !== last || stall_cnt !== m_sc || flush_cnt !== m_fc || bus.state !== RUN) begin
      err++; $display("FAIL hold_frz got %b/%0d/%0d/%0d want %b/%0d/%0d/0",
                      {bus.forward_a, bus.forward_b}, stall_cnt, flush_cnt, bus.state, last, m_sc, m_fc);
    end
    set_id(1, 1, 6, 1, 1, 15, 1, 0, 0, 0);
    chk++;
    if (bus.stall_if_id !== 1'b1) begin err++; $display("FAIL hold_rel got %b want 1", bus.stall_if_id); end
    tick();
    e = q.pop_front(); chk++;
    if (bus.state !== STALL || stall_cnt !== m_sc || {bus.forward_a, bus.forward_b} !== e) begin
      err++; $display("FAIL hold_stall got %0d/%0d want %0d/%0d", bus.state, stall_cnt, STALL, m_sc);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk++;
    if ({bus.stall_if_id, bus.bubble_id_ex, bus.flush, bus.forward_a, bus.forward_b} !== 7'd0 ||
        stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || bus.state !== RUN) begin
      err++; $display("FAIL mid_rst got %b/%0d/%0d/%0d want 0/0/0/0",
                      {bus.stall_if_id, bus.flush, bus.forward_a, bus.forward_b}, stall_cnt, flush_cnt, bus.state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_id(1, 1, 6, 1, 1, 15, 1, 0, 0, 0);
    chk++;
    if (bus.stall_if_id !== 1'b0 || bus.state !== RUN) begin
      err++; $display("FAIL post_rst got %b/%0d want 0/0", bus.stall_if_id, bus.state);
    end
    tick();
    e = q.pop_front(); chk++;
    if ({bus.forward_a, bus.forward_b} !== e) begin err++; $display("FAIL post_rst_fwd got %b want %b", {bus.forward_a, bus.forward_b}, e); end
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; br = 1'b0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.id_rd = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    model_reset();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_x0();
    test_priority();
    test_flush_vs_load();
    test_hold_reset();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

- Producer side of the EX-stage forwarding interface. Generates the `forward_a` and `forward_b` select codes the ALU consumes, plus load-use stall, bubble and branch-flush controls for the 5-stage core.
- Keeps its own shadow pipeline of destination tags: the ID/EX, EX/MEM and MEM/WB destination register, write-enable and load flags.
- Sits beside the ID stage. Forward selects are registered so they are valid during the consuming instruction's EX cycle.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating stall/flush event counters.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: core clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `hold` input 1: global pipeline freeze (memory wait); all state held.
- `id_valid` input 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` input 5 each: source registers of the ID instruction.
- `id_uses_rs1`, `id_uses_rs2` input 1 each: source actually read.
- `id_rd` input 5: destination of the ID instruction.
- `id_reg_write` input 1: ID instruction writes `rd`.
- `id_mem_read` input 1: ID instruction is a load.
- `ex_branch_taken` input 1: EX instruction redirects the PC this cycle.
- `forward_a`, `forward_b` output 2 each: registered selects. 00 = register file, 01 = MEM/WB result, 10 = EX/MEM ALU result. 11 is never driven.
- `stall_if_id` output 1: combinational. Hold PC and IF/ID.
- `bubble_id_ex` output 1: combinational. Load a NOP into ID/EX.
- `flush` output 1: combinational. Kill IF/ID and ID/EX contents.
- `stall_cnt`, `flush_cnt` output CNT_W each: saturating event counters.

## Operation
Shadow stages: `ex_{v,rd,wr,ld}`, `mem_{v,rd,wr}`, `wb_{v,rd,wr}`.

- **Advance rule.** On each edge with `hold=0`:
  - `wb` takes `mem`.
  - `mem` takes `ex`.
  - `ex` takes the ID fields, or becomes invalid (v=0) when a bubble or flush occurs.
- **Match rule.** A source matches a stage when:
  - the stage is valid,
  - its `wr` flag is 1,
  - its `rd` is not 0,
  - its `rd` equals the source register,
  - and the corresponding `id_uses_rs*` is 1.
- **Load-use detection.** `load_use` is set when `id_valid=1` and either source matches `ex` with `ex_ld=1`.
- **Next-cycle forward select.** For each source, computed against the stages the instruction will see in EX:
  - match `ex` (which becomes EX/MEM) with `ex_ld=0` → 10;
  - otherwise match `mem` (which becomes MEM/WB) → 01;
  - otherwise 00.
  - EX/MEM takes priority over MEM/WB.
  - The WB-stage writer is not forwarded. The register file is write-before-read.
- **State machine.**
  - States: RUN, STALL, FLUSH. Encoded in the package.
  - RUN → STALL on `load_use & ~ex_branch_taken & ~hold`.
  - RUN → FLUSH on `ex_branch_taken & ~hold`.
  - STALL → RUN next unhold edge. Exactly one bubble per load-use.
  - FLUSH → RUN next unhold edge.
- **Control outputs.**
  - `stall_if_id = bubble_id_ex = load_use & ~ex_branch_taken & ~hold`.
  - `flush = ex_branch_taken & ~hold`.
- **Simultaneous events.**
  - Flush beats load-use: no stall, no stall count.
  - `hold` beats everything: outputs 0, no state change, counters unchanged.
  - After a bubble, the load sits in `mem`, so the re-evaluated select is 01.
- **Forward registers.** Sampled only on unhold edges:
  - on a normal advance, take the next-cycle select;
  - on a bubble or flush, take 00.
- **Counters.**
  - `stall_cnt` increments on each bubble edge.
  - `flush_cnt` increments on each flush edge.
  - Both saturate at all-ones.

## Timing
- Reset value of every register is 0:
  - all shadow valids, forward registers, counters and state (RUN).
  - Consequently `stall_if_id = bubble_id_ex = 0` out of reset.
  - `flush` follows `ex_branch_taken` even out of reset.
- Forward select latency: computed in the instruction's ID cycle, presented in its EX cycle (1 edge).
- Stall/flush: same-cycle combinational, no registered delay.
- Load-use costs exactly 1 cycle.
- Reset asserted mid-STALL or mid-FLUSH:
  - immediately clears everything;
  - the next cycle after release starts in RUN with empty shadows.
- Combinational path from the `id_*` inputs to `stall_if_id`: comparator plus AND only, no dependence on `forward_*`.

## Structure
Shared package `core_pkg` holds:
- `FWD_REG=2'b00`, `FWD_MEMWB=2'b01`, `FWD_EXMEM=2'b10`,
- the `hz_state_t` enum (RUN, STALL, FLUSH),
- the shadow-stage struct type, so the ALU and the ID/EX register share the encodings.

One natural sub-module: `fwd_select`. It is a pure comparator taking one source register plus the `ex`/`mem` shadows and returning the 2-bit select and load-hit. It is instantiated twice, for rs1 and rs2.

## Test plan
- `add x5` in EX shadow, then ID `sub` with rs1=x5 → next cycle `forward_a`=10, `forward_b`=00, no stall.
- `lw x6` in EX shadow, ID `add` with rs2=x6:
  - → `stall_if_id`=`bubble_id_ex`=1 for one cycle, `stall_cnt`=1;
  - → the cycle after, `forward_b`=01 when the add reaches EX.
- Writer with rd=x0 and `reg_write=1`, ID reads x0 → `forward_a`=00, no stall.
- x7 written by both the EX and MEM shadows, ID reads x7 → `forward_a`=10 (EX/MEM priority).
- Load-use and `ex_branch_taken` asserted in the same cycle → `flush`=1, `stall_if_id`=0, `flush_cnt`=1, `stall_cnt` unchanged.
- `hold`=1 during a load-use, then reset pulsed mid-STALL:
  - → while held, outputs 0 and counters frozen;
  - → after reset, all outputs 0 and state RUN.
